vga_fb_scanout: RTL and testbench
=================================

Name: vga_fb_scanout

Overview:
- Parametrised framebuffer scan-out pipeline between the VGA timing controller and the framebuffer block RAM.
- Maps screen coordinates to a scaled, offset framebuffer window and issues RAM addresses.
- Expands RGB555/RGB565 pixels to 8-bit channels, adds border and test-pattern modes, and delays hsync/vsync/blank to match RAM latency.
- Replaces the fixed 256x256, zero-padded, latency-mismatched scan-out logic in the top level.

Parameters:
- FB_W_BITS, 8: log2 of framebuffer width in pixels.
- FB_H_BITS, 8: log2 of framebuffer height in pixels.
- SCALE_SHIFT, 0: pixel replication factor 2^SCALE_SHIFT in both axes; legal range 0..3.
- X_OFFSET, 0: first screen column of the window.
- Y_OFFSET, 0: first screen row of the window.
- PIX_BITS, 15: 15 selects RGB555, 16 selects RGB565; any other value is an elaboration error.
- RAM_LATENCY, 1: clock cycles from registered address to valid q; legal range 1..3.
- BORDER_RGB, 24'h000000: colour shown when visible but outside the window.

Ports:
- clock  in  1  system clock, CLOCK_50 domain.
- reset  in  1  asynchronous, active-high.
- display_col  in  12  current column from the timing controller.
- display_row  in  11  current row from the timing controller.
- visible  in  1  active-video flag from the timing controller.
- hsync_in  in  1  horizontal sync from the timing controller, active-low.
- vsync_in  in  1  vertical sync from the timing controller, active-low.
- mode_req  in  2  requested mode: 0 = framebuffer, 1 = colour bars, 2 = border only, 3 = reserved (treated as 0).
- address  out  FB_W_BITS+FB_H_BITS  RAM read address, {fb_x, fb_y}.
- pixel  in  PIX_BITS  RAM read data.
- red  out  8  red channel.
- green  out  8  green channel.
- blue  out  8  blue channel.
- hsync  out  1  hsync delayed to match the RGB outputs.
- vsync  out  1  vsync delayed to match the RGB outputs.
- blank_n  out  1  delayed visible; 1 = active video.
- frame_start  out  1  one-cycle pulse at each vsync_in falling edge.
- mode_active  out  2  mode currently applied.

Behaviour:
- Reset (asynchronous) values:
  - address = 0; red, green, blue = 0; hsync = vsync = 1; blank_n = 0; frame_start = 0; mode_active = 0.
  - All delay-line stages reset to idle: sync = 1, visible = 0, in_win = 0.
- Window mapping (combinational, stage 0):
  - x_rel = display_col - X_OFFSET; y_rel = display_row - Y_OFFSET.
  - in_win = (display_col >= X_OFFSET) && (x_rel >> SCALE_SHIFT) < 2^FB_W_BITS, and the same condition on rows using FB_H_BITS.
  - fb_x = (x_rel >> SCALE_SHIFT)[FB_W_BITS-1:0]; fb_y likewise.
- Stage 1: address is registered as {fb_x, fb_y} when in_win, otherwise 0. in_win, visible, fb_x[FB_W_BITS-1 -: 3], hsync_in and vsync_in enter the delay line.
- RAM q is valid at stage 1+RAM_LATENCY. The output registers update at stage 2+RAM_LATENCY.
- Total latency from inputs to red/green/blue/hsync/vsync/blank_n is L = RAM_LATENCY+2 cycles, identical for every output.
- Colour expansion:
  - 5-bit channel c becomes {c, c[4:2]}; 6-bit channel g becomes {g, g[5:4]}.
  - RGB555: R = pixel[14:10], G = pixel[9:5], B = pixel[4:0].
  - RGB565: R = pixel[15:11], G = pixel[10:5], B = pixel[4:0].
- Output colour selection, in priority order:
  - Delayed visible = 0: colour 0.
  - Delayed in_win = 0: BORDER_RGB.
  - Otherwise, by mode_active:
    - 0: expanded pixel.
    - 1: colour bars indexed by the 3 bar bits — 0 white, 1 yellow, 2 cyan, 3 green, 4 magenta, 5 red, 6 blue, 7 black; channels are 8'hFF or 8'h00.
    - 2: BORDER_RGB.
- Mode control FSM: states IDLE_FRAME and LATCH.
  - A vsync_in 1→0 transition, detected with a 1-cycle registered copy of vsync_in, moves to LATCH for one cycle.
  - In LATCH: mode_active <= (mode_req == 3 ? 0 : mode_req); frame_start = 1; then return to IDLE_FRAME.
  - mode_req changes mid-frame have no effect until the next vsync falling edge, so no tearing.
  - vsync_in held low for many cycles produces exactly one pulse.
- Reset asserted mid-line forces all outputs to reset values immediately. The first post-reset valid RGB appears L cycles after the first visible pixel.
- Wrap: display_col < X_OFFSET is out of window, not a modulo wrap. fb_x never aliases because of the explicit range check.

Decomposition:
- Package vga_pkg holds:
  - the mode enum (MODE_FB, MODE_BARS, MODE_BORDER);
  - the colour-bar constant array (8 x 24-bit);
  - the expand5/expand6 functions.
- One sub-module, vga_delay_line (parametrised WIDTH, DEPTH, RESET_VAL; async reset), used for the sync/visible/in_win/bar-index pipeline.

Test Plan:
- Defaults, RAM model returns pixel = 15'h7C00 at address {col, row} = 16'h0A05 → after 3 cycles red = 8'hFF, green = 0, blue = 0; hsync/vsync/blank_n edges are delayed exactly 3 cycles relative to inputs.
- SCALE_SHIFT = 1, X_OFFSET = 64: display_col = 63 gives in_win = 0 and RGB = BORDER_RGB; display_col = 64 and 65 both give fb_x = 0; display_col = 575 gives fb_x = 255; display_col = 576 gives border.
- PIX_BITS = 16, pixel = 16'h07E0 → green = 8'hFF, red = blue = 0; pixel = 16'h0841 → red = 8'h08, green = 8'h08, blue = 8'h08.
- mode_req changed 0→1 mid-frame → output unchanged until vsync_in falls; then frame_start pulses once, mode_active = 1, and fb_x = 8'hE0..FF renders black (bar index 7).
- Reset asserted while visible with RGB = 8'hFF → all outputs immediately 0, hsync/vsync = 1, blank_n = 0; after release, output is stable within L cycles.
- RAM_LATENCY = 3 → latency is 5 cycles and sync-to-RGB alignment is preserved for a 1-pixel-wide white column.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, constants and colour helpers for the framebuffer scan-out path.
package vga_pkg;

  // Display modes; request value 3 is reserved and falls back to the framebuffer.
  typedef enum logic [1:0] {
    MODE_FB     = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_BORDER = 2'd2
  } mode_e;

  // Mode controller states.
  typedef enum logic {
    IDLE_FRAME = 1'b0,
    LATCH      = 1'b1
  } mode_state_e;

  // Colour bars, indexed by the top three bits of fb_x.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF,  // white
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'h00FF00,  // green
    24'hFF00FF,  // magenta
    24'hFF0000,  // red
    24'h0000FF,  // blue
    24'h000000   // black
  };

  // Replicate the top bits into the low bits so full scale maps to 8'hFF.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] g);
    return {g, g[5:4]};
  endfunction

  // Reserved request code is applied as the framebuffer mode.
  function automatic mode_e map_mode(input logic [1:0] req);
    return (req == 2'd3) ? MODE_FB : mode_e'(req);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep side-band signals aligned with RAM data.
module vga_delay_line #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stage_d[gi] = din;
    end else begin : g_tail
      assign stage_d[gi] = stage_q[gi-1];
    end

    // One pipeline stage; reset loads the idle pattern.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        stage_q[gi] <= RESET_VAL;
      end else begin
        stage_q[gi] <= stage_d[gi];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scan-out: screen-to-window mapping, RAM addressing, colour
// expansion, test modes and latency-matched sync/blank outputs.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int          FB_W_BITS   = 8,
  parameter int          FB_H_BITS   = 8,
  parameter int          SCALE_SHIFT = 0,
  parameter int          X_OFFSET    = 0,
  parameter int          Y_OFFSET    = 0,
  parameter int          PIX_BITS    = 15,
  parameter int          RAM_LATENCY = 1,
  parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [11:0]                    display_col,
  input  logic [10:0]                    display_row,
  input  logic                           visible,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic [1:0]                     mode_req,
  output logic [FB_W_BITS+FB_H_BITS-1:0] address,
  input  logic [PIX_BITS-1:0]            pixel,
  output logic [7:0]                     red,
  output logic [7:0]                     green,
  output logic [7:0]                     blue,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           blank_n,
  output logic                           frame_start,
  output logic [1:0]                     mode_active
);

  localparam int AW     = FB_W_BITS + FB_H_BITS;
  localparam int CW     = 13;  // column arithmetic with a guard bit
  localparam int RW     = 12;  // row arithmetic with a guard bit
  localparam int LINE_W = 7;   // {hsync, vsync, visible, in_win, bar[2:0]}
  localparam logic [LINE_W-1:0] LINE_IDLE = 7'b110_0000;

  if (PIX_BITS != 15 && PIX_BITS != 16) begin : g_bad_pix_bits
    $error("vga_fb_scanout: PIX_BITS must be 15 or 16");
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_bad_scale
    $error("vga_fb_scanout: SCALE_SHIFT must be 0..3");
  end
  if (RAM_LATENCY < 1 || RAM_LATENCY > 3) begin : g_bad_latency
    $error("vga_fb_scanout: RAM_LATENCY must be 1..3");
  end
  if (FB_W_BITS < 3 || FB_W_BITS > 11 || FB_H_BITS < 1 || FB_H_BITS > 10) begin : g_bad_fb
    $error("vga_fb_scanout: framebuffer size out of range");
  end

  // Stage 0: window mapping
  logic [CW-1:0]        x_rel, x_scaled;
  logic [RW-1:0]        y_rel, y_scaled;
  logic                 in_win;
  logic [FB_W_BITS-1:0] fb_x;
  logic [FB_H_BITS-1:0] fb_y;

  // Subtract the offset and de-replicate; explicit range checks prevent aliasing.
  always_comb begin
    x_rel    = {1'b0, display_col} - CW'(X_OFFSET);
    y_rel    = {1'b0, display_row} - RW'(Y_OFFSET);
    x_scaled = x_rel >> SCALE_SHIFT;
    y_scaled = y_rel >> SCALE_SHIFT;
    in_win   = ({1'b0, display_col} >= CW'(X_OFFSET))
            && (x_scaled < (CW'(1) << FB_W_BITS))
            && ({1'b0, display_row} >= RW'(Y_OFFSET))
            && (y_scaled < (RW'(1) << FB_H_BITS));
    fb_x     = x_scaled[FB_W_BITS-1:0];
    fb_y     = y_scaled[FB_H_BITS-1:0];
  end

  // Stage 1: RAM address register
  logic [AW-1:0] address_d, address_q;

  always_comb begin
    address_d = in_win ? {fb_x, fb_y} : '0;
  end

  // Address register feeding the block RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_q <= '0;
    end else begin
      address_q <= address_d;
    end
  end

  assign address = address_q;

  // Side-band delay line, matched to address register plus RAM latency
  logic [LINE_W-1:0] line_in, line_out;

  assign line_in = {hsync_in, vsync_in, visible, in_win, fb_x[FB_W_BITS-1 -: 3]};

  vga_delay_line #(
    .WIDTH     (LINE_W),
    .DEPTH     (RAM_LATENCY + 1),
    .RESET_VAL (LINE_IDLE)
  ) u_line (
    .clock (clock),
    .reset (reset),
    .din   (line_in),
    .dout  (line_out)
  );

  // Mode controller: latch the requested mode once per frame
  mode_state_e state_q;
  mode_e       mode_active_q;
  logic        vsync_prev_q;
  logic        frame_start_q;

  // Detect vsync falling edge, then apply mode_req for the whole next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE_FRAME;
      vsync_prev_q  <= 1'b1;
      mode_active_q <= MODE_FB;
      frame_start_q <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_in;
      case (state_q)
        IDLE_FRAME: begin
          frame_start_q <= 1'b0;
          if (vsync_prev_q && !vsync_in) begin
            state_q <= LATCH;
          end
        end
        LATCH: begin
          mode_active_q <= map_mode(mode_req);
          frame_start_q <= 1'b1;
          state_q       <= IDLE_FRAME;
        end
        default: begin
          state_q       <= IDLE_FRAME;
          frame_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign frame_start = frame_start_q;
  assign mode_active = mode_active_q;

  // Output stage: colour selection
  logic        d_hs, d_vs, d_vis, d_win;
  logic [2:0]  d_bar;
  logic [15:0] px16;
  logic [23:0] fb_rgb;
  logic [23:0] rgb_d, rgb_q;
  logic        hsync_d, hsync_q, vsync_d, vsync_q, blank_n_d, blank_n_q;

  // Pick the output colour: blanking, then border, then the active mode.
  always_comb begin
    {d_hs, d_vs, d_vis, d_win, d_bar} = line_out;
    px16 = 16'(pixel);
    if (PIX_BITS == 16) begin
      fb_rgb = {expand5(px16[15:11]), expand6(px16[10:5]), expand5(px16[4:0])};
    end else begin
      fb_rgb = {expand5(px16[14:10]), expand5(px16[9:5]), expand5(px16[4:0])};
    end

    rgb_d = 24'h000000;
    if (!d_vis) begin
      rgb_d = 24'h000000;
    end else if (!d_win) begin
      rgb_d = BORDER_RGB;
    end else begin
      case (mode_active_q)
        MODE_FB:   rgb_d = fb_rgb;
        MODE_BARS: rgb_d = BAR_RGB[d_bar];
        default:   rgb_d = BORDER_RGB;
      endcase
    end

    hsync_d   = d_hs;
    vsync_d   = d_vs;
    blank_n_d = d_vis;
  end

  // Final output registers; every output leaves through the same stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q     <= 24'h000000;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: instance A uses default parameters, instance B uses
// 2x scaling, an offset window, RGB565, 3-cycle RAM and a non-black border.
module tb_vga_fb_scanout;

  localparam int LAT_A = 3;
  localparam int LAT_B = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] display_col = '0;
  logic [10:0] display_row = '0;
  logic        visible = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [1:0]  mode_req = 2'd0;

  always #10 clock = ~clock;

  logic [15:0] address_a, address_b;
  logic [14:0] pixel_a;
  logic [15:0] pixel_b;
  logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic        hsync_a, vsync_a, blank_n_a, frame_start_a;
  logic        hsync_b, vsync_b, blank_n_b, frame_start_b;
  logic [1:0]  mode_active_a, mode_active_b;

  vga_fb_scanout u_dut_a (
    .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
    .visible(visible), .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_req(mode_req),
    .address(address_a), .pixel(pixel_a), .red(red_a), .green(green_a), .blue(blue_a),
    .hsync(hsync_a), .vsync(vsync_a), .blank_n(blank_n_a), .frame_start(frame_start_a),
    .mode_active(mode_active_a)
  );

  vga_fb_scanout #(
    .SCALE_SHIFT(1), .X_OFFSET(64), .Y_OFFSET(16), .PIX_BITS(16),
    .RAM_LATENCY(3), .BORDER_RGB(24'h123456)
  ) u_dut_b (
    .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
    .visible(visible), .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_req(mode_req),
    .address(address_b), .pixel(pixel_b), .red(red_b), .green(green_b), .blue(blue_b),
    .hsync(hsync_b), .vsync(vsync_b), .blank_n(blank_n_b), .frame_start(frame_start_b),
    .mode_active(mode_active_b)
  );

  // Framebuffer RAM models
  logic [15:0] mem_a [65536];
  logic [15:0] mem_b [65536];
  logic [15:0] qa, qb1, qb2, qb3;

  always @(posedge clock) begin
    qa  <= mem_a[address_a];
    qb1 <= mem_b[address_b];
    qb2 <= qb1;
    qb3 <= qb2;
  end

  assign pixel_a = qa[14:0];
  assign pixel_b = qb3;

  logic [23:0] rgb_w  [2];
  logic [2:0]  sync_w [2];
  logic [15:0] addr_w [2];
  assign rgb_w[0]  = {red_a, green_a, blue_a};
  assign rgb_w[1]  = {red_b, green_b, blue_b};
  assign sync_w[0] = {hsync_a, vsync_a, blank_n_a};
  assign sync_w[1] = {hsync_b, vsync_b, blank_n_b};
  assign addr_w[0] = address_a;
  assign addr_w[1] = address_b;

  int vectors = 0;
  int miscompares = 0;
  int model_mode = 0;
  logic [23:0] bar_tbl [8];

  // History of inputs as sampled on each clock edge
  typedef struct {
    int col;
    int row;
    bit vis;
    bit hs;
    bit vs;
  } samp_t;
  samp_t hist[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hist.delete();
    end else begin
      hist.push_back('{int'(display_col), int'(display_row), visible, hsync_in, vsync_in});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  // Reference model
  function automatic bit m_in_win(int inst, int col, int row);
    int xo, yo, s;
    xo = (inst == 1) ? 64 : 0;
    yo = (inst == 1) ? 16 : 0;
    s  = (inst == 1) ? 1 : 0;
    if (col < xo || row < yo) return 1'b0;
    return (((col - xo) >> s) < 256) && (((row - yo) >> s) < 256);
  endfunction

  function automatic logic [15:0] m_addr(int inst, int col, int row);
    int s, fx, fy;
    if (!m_in_win(inst, col, row)) return 16'h0000;
    s  = (inst == 1) ? 1 : 0;
    fx = (col - ((inst == 1) ? 64 : 0)) >> s;
    fy = (row - ((inst == 1) ? 16 : 0)) >> s;
    return 16'(fx * 256 + fy);
  endfunction

  function automatic logic [23:0] m_rgb(int inst, samp_t e, int mode);
    int fx, w, r, g, b;
    logic [23:0] border;
    border = (inst == 1) ? 24'h123456 : 24'h000000;
    if (!e.vis) return 24'h000000;
    if (!m_in_win(inst, e.col, e.row)) return border;
    if (mode == 2) return border;
    fx = (e.col - ((inst == 1) ? 64 : 0)) >> ((inst == 1) ? 1 : 0);
    if (mode == 1) return bar_tbl[fx / 32];
    if (inst == 1) begin
      w = int'(mem_b[m_addr(inst, e.col, e.row)]);
      r = (w >> 11) & 31; g = (w >> 5) & 63; b = w & 31;
      return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    end
    w = int'(mem_a[m_addr(inst, e.col, e.row)]);
    r = (w >> 10) & 31; g = (w >> 5) & 31; b = w & 31;
    return {8'(r * 8 + r / 4), 8'(g * 8 + g / 4), 8'(b * 8 + b / 4)};
  endfunction

  // Stimulus helpers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(int col, int row, bit vis, bit hs, bit vs);
    display_col = 12'(col);
    display_row = 11'(row);
    visible     = vis;
    hsync_in    = hs;
    vsync_in    = vs;
  endtask

  task automatic idle(int n);
    drive(800, 600, 1'b0, 1'b1, 1'b1);
    repeat (n) tick();
  endtask

  task automatic vsync_pulse();
    drive(800, 600, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    drive(800, 600, 1'b0, 1'b1, 1'b1);
    repeat (6) tick();
  endtask

  // Tests
  task automatic test_reset();
    idle(0);
    #1 reset = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rgb_w[i] !== 24'h0) begin
        miscompares++; $display("FAIL reset_rgb inst%0d got %h expected 000000", i, rgb_w[i]);
      end
      vectors++;
      if (sync_w[i] !== 3'b110) begin
        miscompares++; $display("FAIL reset_sync inst%0d got %b expected 110", i, sync_w[i]);
      end
      vectors++;
      if (addr_w[i] !== 16'h0) begin
        miscompares++; $display("FAIL reset_addr inst%0d got %h expected 0000", i, addr_w[i]);
      end
    end
    vectors++;
    if ({frame_start_a, mode_active_a, frame_start_b, mode_active_b} !== 6'b0) begin
      miscompares++; $display("FAIL reset_mode got fs/mode %b%b %b%b expected 0",
                              frame_start_a, mode_active_a, frame_start_b, mode_active_b);
    end
    @(negedge clock) reset = 1'b0;
    idle(6);
  endtask

  task automatic test_pixel_latency();
    mem_a[16'h0A05] = 16'h7C00;
    idle(6);
    drive(10, 5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        drive(800, 600, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (address_a !== 16'h0A05) begin
          miscompares++; $display("FAIL lat_addr got %h expected 0a05", address_a);
        end
      end
      vectors++;
      if (rgb_w[0] !== ((k == 2) ? 24'hFF0000 : 24'h0)) begin
        miscompares++; $display("FAIL lat_rgb k=%0d got %h expected %h", k, rgb_w[0],
                                (k == 2) ? 24'hFF0000 : 24'h0);
      end
      vectors++;
      if (sync_w[0] !== ((k == 2) ? 3'b001 : 3'b110)) begin
        miscompares++; $display("FAIL lat_sync k=%0d got %b expected %b", k, sync_w[0],
                                (k == 2) ? 3'b001 : 3'b110);
      end
    end
  endtask

  task automatic test_window_edges();
    int          cols [5]   = '{63, 64, 65, 575, 576};
    logic [15:0] e_addr [5] = '{16'h0000, 16'h0001, 16'h0001, 16'hFF01, 16'h0000};
    logic [23:0] e_rgb [5]  = '{24'h123456, 24'h00FF00, 24'h00FF00, 24'h080808, 24'h123456};
    logic [23:0] exp_rgb;
    mem_b[16'h0001] = 16'h07E0;
    mem_b[16'hFF01] = 16'h0841;
    idle(6);
    for (int k = 0; k < 10; k++) begin
      if (k < 5) drive(cols[k], 18, 1'b1, 1'b1, 1'b1);
      else       drive(800, 600, 1'b0, 1'b1, 1'b1);
      tick();
      if (k < 5) begin
        vectors++;
        if (address_b !== e_addr[k]) begin
          miscompares++; $display("FAIL win_addr col=%0d got %h expected %h", cols[k], address_b, e_addr[k]);
        end
      end
      exp_rgb = (k >= 4 && k < 9) ? e_rgb[k-4] : 24'h0;
      vectors++;
      if (rgb_w[1] !== exp_rgb) begin
        miscompares++; $display("FAIL win_rgb k=%0d got %h expected %h", k, rgb_w[1], exp_rgb);
      end
    end
  endtask

  task automatic test_white_column();
    int cols [3] = '{99, 100, 102};
    bit hs [3]   = '{1'b1, 1'b0, 1'b1};
    mem_b[16'h1102] = 16'h0000;
    mem_b[16'h1202] = 16'hFFFF;
    mem_b[16'h1302] = 16'h0000;
    idle(6);
    for (int k = 0; k < 9; k++) begin
      if (k < 3) drive(cols[k], 20, 1'b1, hs[k], 1'b1);
      else       drive(800, 600, 1'b0, 1'b1, 1'b1);
      tick();
      vectors++;
      if (rgb_w[1] !== ((k == 5) ? 24'hFFFFFF : 24'h0)) begin
        miscompares++; $display("FAIL col_rgb k=%0d got %h", k, rgb_w[1]);
      end
      vectors++;
      if (hsync_b !== (k != 5) || blank_n_b !== (k >= 4 && k <= 6)) begin
        miscompares++; $display("FAIL col_sync k=%0d got hs=%b blank_n=%b expected hs=%b blank_n=%b",
                                k, hsync_b, blank_n_b, (k != 5), (k >= 4 && k <= 6));
      end
    end
  endtask

  task automatic test_mode_switch();
    int fs_a = 0;
    int fs_b = 0;
    mem_a[16'hE503] = 16'h7FFF;
    idle(6);
    // Mid-frame request must not take effect yet
    mode_req = 2'd1;
    drive(8'hE5, 3, 1'b1, 1'b1, 1'b1);
    tick();
    idle(2);
    vectors++;
    if (rgb_w[0] !== 24'hFFFFFF || mode_active_a !== 2'd0) begin
      miscompares++; $display("FAIL mode_hold got rgb=%h mode=%0d expected ffffff mode=0", rgb_w[0], mode_active_a);
    end
    // Long vsync low: exactly one frame_start pulse
    drive(800, 600, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k == 8) drive(800, 600, 1'b0, 1'b1, 1'b1);
      tick();
      fs_a += int'(frame_start_a);
      fs_b += int'(frame_start_b);
    end
    vectors++;
    if (fs_a != 1 || fs_b != 1) begin
      miscompares++; $display("FAIL frame_start pulses got %0d/%0d expected 1/1", fs_a, fs_b);
    end
    vectors++;
    if (mode_active_a !== 2'd1 || mode_active_b !== 2'd1) begin
      miscompares++; $display("FAIL mode_latch got %0d/%0d expected 1/1", mode_active_a, mode_active_b);
    end
    // Colour bars: fb_x E5 is black, fb_x 05 is white
    for (int k = 0; k < 7; k++) begin
      if (k == 0)      drive(8'hE5, 3, 1'b1, 1'b1, 1'b1);
      else if (k == 1) drive(522, 16, 1'b1, 1'b1, 1'b1);
      else if (k == 2) drive(5, 3, 1'b1, 1'b1, 1'b1);
      else             drive(800, 600, 1'b0, 1'b1, 1'b1);
      tick();
      if (k == 2) begin
        vectors++;
        if (rgb_w[0] !== 24'h0 || blank_n_a !== 1'b1) begin
          miscompares++; $display("FAIL bars_black_a got rgb=%h blank_n=%b expected 000000/1", rgb_w[0], blank_n_a);
        end
      end
      if (k == 4) begin
        vectors++;
        if (rgb_w[0] !== 24'hFFFFFF) begin
          miscompares++; $display("FAIL bars_white_a got %h expected ffffff", rgb_w[0]);
        end
      end
      if (k == 5) begin
        vectors++;
        if (rgb_w[1] !== 24'h0 || blank_n_b !== 1'b1) begin
          miscompares++; $display("FAIL bars_black_b got rgb=%h blank_n=%b expected 000000/1", rgb_w[1], blank_n_b);
        end
      end
    end
    // Border-only mode
    mode_req = 2'd2;
    vsync_pulse();
    vectors++;
    if (mode_active_a !== 2'd2) begin
      miscompares++; $display("FAIL mode_border got %0d expected 2", mode_active_a);
    end
    drive(100, 30, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) drive(800, 600, 1'b0, 1'b1, 1'b1);
      if (k == 2) begin
        vectors++;
        if (rgb_w[0] !== 24'h0 || blank_n_a !== 1'b1) begin
          miscompares++; $display("FAIL border_a got rgb=%h blank_n=%b expected 000000/1", rgb_w[0], blank_n_a);
        end
      end
      if (k == 4) begin
        vectors++;
        if (rgb_w[1] !== 24'h123456) begin
          miscompares++; $display("FAIL border_b got %h expected 123456", rgb_w[1]);
        end
      end
    end
    // Reserved request falls back to framebuffer
    mode_req = 2'd3;
    vsync_pulse();
    vectors++;
    if (mode_active_a !== 2'd0 || mode_active_b !== 2'd0) begin
      miscompares++; $display("FAIL mode_reserved got %0d/%0d expected 0/0", mode_active_a, mode_active_b);
    end
    mode_req = 2'd0;
  endtask

  task automatic test_reset_midline();
    idle(6);
    drive(10, 5, 1'b1, 1'b1, 1'b1);
    repeat (5) tick();
    vectors++;
    if (rgb_w[0] !== 24'hFF0000) begin
      miscompares++; $display("FAIL pre_reset_rgb got %h expected ff0000", rgb_w[0]);
    end
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rgb_w[i] !== 24'h0 || sync_w[i] !== 3'b110 || addr_w[i] !== 16'h0) begin
        miscompares++; $display("FAIL midline_reset inst%0d got rgb=%h sync=%b addr=%h expected 000000/110/0000",
                                i, rgb_w[i], sync_w[i], addr_w[i]);
      end
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    model_mode = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (rgb_w[0] !== ((k >= 2) ? 24'hFF0000 : 24'h0) || blank_n_a !== (k >= 2)) begin
        miscompares++; $display("FAIL post_reset k=%0d got rgb=%h blank_n=%b", k, rgb_w[0], blank_n_a);
      end
    end
  endtask

  task automatic test_random(int mode, int n);
    samp_t       e;
    logic [23:0] er;
    logic [2:0]  es;
    logic [15:0] ea;
    int          lat;
    mode_req = 2'(mode);
    vsync_pulse();
    model_mode = (mode == 3) ? 0 : mode;
    for (int c = 0; c < n; c++) begin
      drive($urandom_range(0, 700), $urandom_range(0, 560), ($urandom % 8) != 0,
            1'($urandom), 1'($urandom));
      tick();
      for (int i = 0; i < 2; i++) begin
        lat = (i == 1) ? LAT_B : LAT_A;
        if (hist.size() >= lat) begin
          e  = hist[hist.size() - lat];
          er = m_rgb(i, e, model_mode);
          es = {e.hs, e.vs, e.vis};
        end else begin
          er = 24'h0;
          es = 3'b110;
        end
        ea = m_addr(i, hist[hist.size()-1].col, hist[hist.size()-1].row);
        vectors++;
        if (rgb_w[i] !== er) begin
          miscompares++; $display("FAIL rand_rgb mode=%0d inst%0d got %h expected %h", mode, i, rgb_w[i], er);
        end
        vectors++;
        if (sync_w[i] !== es) begin
          miscompares++; $display("FAIL rand_sync mode=%0d inst%0d got %b expected %b", mode, i, sync_w[i], es);
        end
        vectors++;
        if (addr_w[i] !== ea) begin
          miscompares++; $display("FAIL rand_addr mode=%0d inst%0d got %h expected %h", mode, i, addr_w[i], ea);
        end
      end
    end
    mode_req = 2'd0;
  endtask

  initial begin
    bar_tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
    test_reset();
    test_pixel_latency();
    test_window_edges();
    test_white_column();
    test_mode_switch();
    test_reset_midline();
    test_random(0, 250);
    test_random(1, 200);
    test_random(2, 150);
    test_random(3, 150);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
